// File: rtl/erx_rdback_sched_pkg.sv
// Shared elink readback definitions: source indices and counter helpers.
// Every readback block should use these names for its sources.
package erx_rdback_sched_pkg;

  localparam int RDB_RX      = 0;
  localparam int RDB_MAILBOX = 1;
  localparam int RDB_DMA     = 2;
  localparam int RDB_TX      = 3;
  localparam int RDB_NSRC    = 4;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Saturating 8-bit add for the drop counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? DROP_MAX : s[7:0];
  endfunction

endpackage

// File: rtl/erx_rr_grant.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr, wrapping modulo N. Produces a one-hot grant.
module erx_rr_grant #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/erx_rdback_sched.sv
// Readback scheduler: one holding slot per source, round-robin drain into a
// single stallable output register, with a saturating drop counter.
module erx_rdback_sched
  import erx_rdback_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         req_wait,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_wait,
  output logic [7:0]           drop_count,
  input  logic                 drop_clear
);

  localparam int SW = $clog2(N);

  logic [DW-1:0] slot [N];
  logic [N-1:0]  full;
  logic [N-1:0]  grant;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] gidx;
  logic [SW-1:0] rr_next;
  logic [7:0]    drop_inc;
  logic          free;
  logic          any_grant;

  assign req_wait  = full;
  assign free      = !out_valid || !out_wait;
  assign any_grant = |grant;

  // Arbitration only runs when the output register can take a new word.
  erx_rr_grant #(.N(N)) u_rr_grant (
    .req   (full & {N{free}}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    gidx     = '0;
    drop_inc = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gidx = SW'(i);
      drop_inc = drop_inc + 8'(req_valid[i] & full[i]);
    end
  end

  assign rr_next = (gidx == SW'(N - 1)) ? '0 : gidx + 1'b1;

  // A slot being drained this edge still reads as full, so a same-cycle
  // refill lands in drop_inc rather than the slot.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      full       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      full <= (full & ~grant) | (req_valid & ~full);
      if (free) begin
        if (any_grant) begin
          out_valid <= 1'b1;
          out_data  <= slot[gidx];
          out_src   <= gidx;
          rr_ptr    <= rr_next;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (drop_clear) drop_count <= '0;
      else            drop_count <= sat_add8(drop_count, drop_inc);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !full[i]) slot[i] <= req_data[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_erx_rdback_sched.sv
// Bench for erx_rdback_sched: directed vector table, hand-written corner
// sequences, then random traffic against an untimed reference model.
module tb_erx_rdback_sched;

  localparam int N  = 4;
  localparam int DW = 32;

  logic           clk;
  logic           nreset;
  logic [N-1:0]   req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]   req_wait;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_src;
  logic           out_wait;
  logic [7:0]     drop_count;
  logic           drop_clear;

  int n_cmp;
  int n_fail;

  erx_rdback_sched #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_wait   (req_wait),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_wait   (out_wait),
    .drop_count (drop_count),
    .drop_clear (drop_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [3:0]   rv;
    logic [127:0] rd;
    logic         ow;
    logic [3:0]   ewait;
    logic         eov;
    logic [31:0]  edata;
    logic [1:0]   esrc;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  bit          m_full [N];
  logic [31:0] m_slot [N];
  bit          m_ov;
  logic [31:0] m_od;
  int          m_os;
  int          m_rr;
  int          m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    nreset     = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    out_wait   = 1'b0;
    drop_clear = 1'b0;
    #2;
    nreset = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0;
      m_slot[i] = '0;
    end
    m_ov = 0; m_od = '0; m_os = 0; m_rr = 0; m_drop = 0;
  endtask

  // Applies one clock edge's worth of the scheduling rules to the model.
  task automatic model_step(input logic [3:0] rv, input logic [127:0] rd,
                            input logic ow, input logic clr);
    bit free;
    int g;
    int drops;
    free  = !m_ov || !ow;
    g     = -1;
    drops = 0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && m_full[idx]) g = idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rv[i] && m_full[i]) drops++;
      else if (rv[i]) begin
        m_full[i] = 1;
        m_slot[i] = rd[i*32 +: 32];
      end
    end
    if (g >= 0) begin
      m_ov = 1; m_od = m_slot[g]; m_os = g; m_rr = (g + 1) % N; m_full[g] = 0;
    end else if (free) begin
      m_ov = 0;
    end
    if (clr) m_drop = 0;
    else m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    do_reset();
    chk("reset_req_wait", 32'(req_wait), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_drop_count", 32'(drop_count), 0);

    // single push, simultaneous push, stall
    vecs.push_back('{1'b1, 4'b0001, 128'hDEADBEEF, 1'b0, 4'b0001, 1'b0, 32'h0, 2'd0});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd0});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 4'b1111, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b0, 4'b1111, 1'b0, 32'h0, 2'd0});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b1110, 1'b1, 32'h10, 2'd0});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b1100, 1'b1, 32'h11, 2'd1});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b1000, 1'b1, 32'h12, 2'd2});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b1, 32'h13, 2'd3});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 4'b0100, {32'h0, 32'hA5A5A5A5, 64'h0}, 1'b0, 4'b0100, 1'b0, 32'h0, 2'd0});
    vecs.push_back('{1'b0, 4'b0001, 128'h5, 1'b0, 4'b0001, 1'b1, 32'hA5A5A5A5, 2'd2});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b1, 4'b0001, 1'b1, 32'hA5A5A5A5, 2'd2});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b1, 32'h5, 2'd0});
    vecs.push_back('{1'b0, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      req_valid = vecs[i].rv;
      req_data  = vecs[i].rd;
      out_wait  = vecs[i].ow;
      cycle();
      chk($sformatf("vec%0d_req_wait", i), 32'(req_wait), 32'(vecs[i].ewait));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      if (vecs[i].eov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].edata);
        chk($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vecs[i].esrc));
      end
    end

    // fairness: sources 1 and 3 keep pushing
    do_reset();
    req_valid = 4'b1010;
    for (int c = 1; c <= 12; c++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      if (c == 1) chk("fair_first_valid", 32'(out_valid), 0);
      else begin
        chk($sformatf("fair%0d_valid", c), 32'(out_valid), 1);
        chk($sformatf("fair%0d_src", c), 32'(out_src), (c % 2 == 0) ? 1 : 3);
      end
    end

    // drop counting, saturation and clear priority
    do_reset();
    req_valid = 4'b0001;
    req_data  = 128'h77;
    out_wait  = 1'b1;
    repeat (10) cycle();
    chk("drop_after10", 32'(drop_count), 8);
    repeat (290) cycle();
    chk("drop_saturated", 32'(drop_count), 255);
    drop_clear = 1'b1;
    cycle();
    chk("drop_clear_priority", 32'(drop_count), 0);
    drop_clear = 1'b0;
    cycle();
    chk("drop_restart", 32'(drop_count), 1);
    req_valid  = '0;
    drop_clear = 1'b1;
    cycle();
    chk("drop_clear_idle", 32'(drop_count), 0);
    drop_clear = 1'b0;

    // reset mid-operation with three slots full and the output held
    do_reset();
    req_valid = 4'b1111;
    req_data  = {32'h33, 32'h22, 32'h11, 32'h99};
    out_wait  = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    chk("pre_rst_req_wait", 32'(req_wait), 32'hE);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("rst_req_wait", 32'(req_wait), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    #1;
    nreset   = 1'b1;
    out_wait = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk($sformatf("post_rst%0d_valid", c), 32'(out_valid), 0);
      chk($sformatf("post_rst%0d_wait", c), 32'(req_wait), 0);
    end

    // random traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] rv;
      logic       ow;
      logic       clr;
      logic [127:0] rd;
      rv  = 4'($urandom);
      rd  = {$urandom, $urandom, $urandom, $urandom};
      ow  = (c % 500 < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      req_valid  = rv;
      req_data   = rd;
      out_wait   = ow;
      drop_clear = clr;
      model_step(rv, rd, ow, clr);
      cycle();
      chk($sformatf("rnd%0d_req_wait", c), 32'(req_wait),
          32'({m_full[3], m_full[2], m_full[1], m_full[0]}));
      chk($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk($sformatf("rnd%0d_out_data", c), out_data, m_od);
        chk($sformatf("rnd%0d_out_src", c), 32'(out_src), 32'(m_os));
      end
      chk($sformatf("rnd%0d_drop", c), 32'(drop_count), 32'(m_drop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
